mem_port_arbiter: RTL

- Shares the single physical-memory port between the instruction cache and the data cache.
- Accepts line-sized read requests from the I-cache and read/write requests from the D-cache. Grants exactly one requester at a time and drives the memory port from registered copies of that requester's command.
- Routes the single-cycle memory response back to the granted cache only.
- Sits between the two L1 caches and physical memory. The pipeline stall logic sees its per-cache resp pulses as ordinary cache responses.

---
 rtl/lc3b_types.sv | 9 +
 rtl/mem_port_arbiter_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational tie-break between the I-cache and D-cache requests.
// grant is one-hot {D, I}; last_grant is 1 when D was granted last.
module arb_pick (
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (i_req && d_req)
            grant = last_grant ? 2'b01 : 2'b10;
        else if (d_req)
            grant = 2'b10;
        else if (i_req)
            grant = 2'b01;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D always wins ties.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int LINE_W = $bits(lc3b_line)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    logic       i_req, d_req, last_grant;
    logic [1:0] grant;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            last_grant <= 1'b0;
        else if (state == IDLE && grant != 2'b00)
            last_grant <= grant[1];
    end
`else
    assign last_grant = 1'b0;
`endif

    // The pmem strobes and command fields are the latched command registers,
    // so they stay stable for the whole grant regardless of requester inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[1]) begin
                        state        <= GRANT_D;
                        pmem_read    <= ~d_write;
                        pmem_write   <= d_write;
                        pmem_address <= d_address;
                        pmem_wdata   <= d_wdata;
                    end else if (grant[0]) begin
                        state        <= GRANT_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= i_address;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (pmem_resp) begin
                        state      <= DONE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_resp  = (state == GRANT_I) && pmem_resp;
    assign d_resp  = (state == GRANT_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
